// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin scheduler that sends single chars and ASCII decimal counts to a byte UART
module uart_tx_scheduler #(
  parameter bit CRLF_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_char,
  input  logic [7:0]  char_data,
  input  logic        req_cnt,
  input  logic [13:0] cnt_value,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CONV, START, WAIT} state_t;
  state_t      state_q, state_d;
  logic        p_char_q, p_char_d, p_cnt_q, p_cnt_d;
  logic [7:0]  char_q, char_d;
  logic [13:0] cnt_q, cnt_d, bin_q, bin_d, sat;
  logic [15:0] bcd_q, bcd_d, adj;
  logic [3:0]  step_q, step_d, digit;
  logic [2:0]  idx_q, idx_d, last_idx;
  logic        last_cnt_q, last_cnt_d, src_cnt_q, src_cnt_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d, cur_byte;
  logic        grant_cnt, grant_char;
  assign sat        = cnt_q > 14'd9999 ? 14'd9999 : cnt_q;
  assign grant_cnt  = p_cnt_q && (!p_char_q || !last_cnt_q);
  assign grant_char = p_char_q && !grant_cnt;
  assign digit      = idx_q[1:0] == 2'd0 ? bcd_q[15:12] :
                      idx_q[1:0] == 2'd1 ? bcd_q[11:8]  :
                      idx_q[1:0] == 2'd2 ? bcd_q[7:4]   : bcd_q[3:0];
  // a char frame reuses the low byte of the BCD register to hold its byte
  assign cur_byte   = !src_cnt_q ? bcd_q[7:0] :
                      idx_q == 3'd4 ? 8'h0D :
                      idx_q == 3'd5 ? 8'h0A : {4'h3, digit};
  assign last_idx   = !src_cnt_q ? 3'd0 : CRLF_EN ? 3'd5 : 3'd3;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign busy       = state_q != IDLE || p_char_q || p_cnt_q;
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] > 4'd4 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end
  always_comb begin
    state_d    = state_q;
    p_char_d   = p_char_q;
    p_cnt_d    = p_cnt_q;
    char_d     = char_q;
    cnt_d      = cnt_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    step_d     = step_q;
    idx_d      = idx_q;
    last_cnt_d = last_cnt_q;
    src_cnt_d  = src_cnt_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    unique case (state_q)
      IDLE: begin
        if (grant_char) begin
          p_char_d  = 1'b0;
          src_cnt_d = 1'b0;
          bcd_d     = {8'h00, char_q};
          idx_d     = 3'd0;
          state_d   = START;
        end else if (grant_cnt) begin
          p_cnt_d   = 1'b0;
          src_cnt_d = 1'b1;
          bin_d     = sat;
          bcd_d     = 16'h0000;
          step_d    = 4'd0;
          idx_d     = 3'd0;
          state_d   = CONV;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {adj[14:0], bin_q, 1'b0};
        step_d         = step_q + 4'd1;
        state_d        = step_q == 4'd13 ? START : CONV;
      end
      START: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = cur_byte;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          idx_d      = idx_q + 3'd1;
          state_d    = idx_q == last_idx ? IDLE : START;
          last_cnt_d = idx_q == last_idx ? src_cnt_q : last_cnt_q;
        end
      end
    endcase
    if (req_char) begin
      p_char_d = 1'b1;
      char_d   = char_data;
    end
    if (req_cnt) begin
      p_cnt_d = 1'b1;
      cnt_d   = cnt_value;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      p_char_q   <= 1'b0;
      p_cnt_q    <= 1'b0;
      char_q     <= 8'h00;
      cnt_q      <= 14'd0;
      bin_q      <= 14'd0;
      bcd_q      <= 16'h0000;
      step_q     <= 4'd0;
      idx_q      <= 3'd0;
      last_cnt_q <= 1'b1;
      src_cnt_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      p_char_q   <= p_char_d;
      p_cnt_q    <= p_cnt_d;
      char_q     <= char_d;
      cnt_q      <= cnt_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      step_q     <= step_d;
      idx_q      <= idx_d;
      last_cnt_q <= last_cnt_d;
      src_cnt_q  <= src_cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard bench; a behavioural UART answers each tx_start with busy then a done pulse
module tb_uart_tx_scheduler;
  logic        clk = 1'b0, reset = 1'b1, req_char = 1'b0, req_cnt = 1'b0;
  logic        tx_done = 1'b0, tx_busy_m = 1'b0, hold_busy = 1'b0, unstable = 1'b0;
  logic [7:0]  char_data = 8'h00, held = 8'h00;
  logic [13:0] cnt_value = 14'd0;
  logic        tx_busy, tx_start, busy;
  logic [7:0]  tx_data;
  int          cyc = 0, req_edge = 0, left = 0, n_checks = 0, n_fail = 0;
  logic [7:0]  exp_q[$], got_q[$];
  int          start_cyc_q[$];

  uart_tx_scheduler #(.CRLF_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .req_char(req_char), .char_data(char_data),
    .req_cnt(req_cnt), .cnt_value(cnt_value), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_start(tx_start), .tx_data(tx_data), .busy(busy)
  );

  assign tx_busy = tx_busy_m | hold_busy;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART model: every observed tx_start is logged; the first of a byte starts a 4-cycle busy window
  always begin
    @(posedge clk);
    #1;
    tx_done = 1'b0;
    if (reset) begin
      tx_busy_m = 1'b0;
      left = 0;
    end else begin
      if (tx_start) begin
        got_q.push_back(tx_data);
        start_cyc_q.push_back(cyc);
      end
      if (left > 0) begin
        if (tx_data !== held) unstable = 1'b1;
        left--;
        if (left == 0) begin
          tx_done = 1'b1;
          tx_busy_m = 1'b0;
        end
      end else if (tx_start) begin
        held = tx_data;
        left = 4;
        tx_busy_m = 1'b1;
      end
    end
  end

  task automatic pulse(input logic c, input logic [7:0] d, input logic k, input logic [13:0] v);
    @(negedge clk);
    req_char = c;
    char_data = c ? d : char_data;
    req_cnt = k;
    cnt_value = k ? v : cnt_value;
    req_edge = cyc + 1;
    @(negedge clk);
    req_char = 1'b0;
    req_cnt = 1'b0;
  endtask

  task automatic clear();
    got_q.delete();
    start_cyc_q.delete();
    exp_q.delete();
    unstable = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && !tx_busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic push_count(input int v);
    int s;
    s = v > 9999 ? 9999 : v;
    exp_q.push_back(8'h30 + 8'(s / 1000));
    exp_q.push_back(8'h30 + 8'((s / 100) % 10));
    exp_q.push_back(8'h30 + 8'((s / 10) % 10));
    exp_q.push_back(8'h30 + 8'(s % 10));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  function automatic logic [8:0] pop_got();
    return got_q.size() != 0 ? {1'b1, got_q.pop_front()} : 9'h000;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    req_char = 1'b1;
    char_data = 8'h5A;
    req_cnt = 1'b1;
    cnt_value = 14'd77;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    req_char = 1'b0;
    req_cnt = 1'b0;
    clear();
    repeat (30) @(negedge clk);
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b, required 0", tx_start); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL reset_req_ignored: got %0d starts, required 0", got_q.size()); end
  endtask

  task automatic test_char();
    bit to;
    logic [8:0] g;
    logic [7:0] e;
    int lat;
    clear();
    pulse(1'b1, 8'h33, 1'b0, 14'd0);
    exp_q.push_back(8'h33);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL char_busy: got %b, required 1", busy); end
    wait_idle(200, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL char_idle: busy=%b after 200 cycles, required 0", busy); end
    lat = start_cyc_q.size() != 0 ? start_cyc_q[0] - req_edge : -1;
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL char_latency: got %0d, required 2", lat); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = pop_got();
      n_checks++; if (g !== {1'b1, e}) begin n_fail++; $display("FAIL char_byte: got %h, required %h", g, {1'b1, e}); end
    end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL char_extra: got %0d extra starts, required 0", got_q.size()); end
  endtask

  task automatic test_count(input int v, input string name);
    bit to;
    logic [8:0] g;
    logic [7:0] e;
    int lat;
    clear();
    pulse(1'b0, 8'h00, 1'b1, 14'(v));
    push_count(v);
    wait_idle(400, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL %s_idle: busy=%b after 400 cycles, required 0", name, busy); end
    lat = start_cyc_q.size() != 0 ? start_cyc_q[0] - req_edge : -1;
    n_checks++; if (lat != 16) begin n_fail++; $display("FAIL %s_latency: got %0d, required 16", name, lat); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = pop_got();
      n_checks++; if (g !== {1'b1, e}) begin n_fail++; $display("FAIL %s_byte: got %h, required %h", name, g, {1'b1, e}); end
    end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL %s_extra: got %0d extra starts, required 0", name, got_q.size()); end
    n_checks++; if (unstable) begin n_fail++; $display("FAIL %s_stable: tx_data changed before tx_done, required stable", name); end
  endtask

  task automatic test_round_robin();
    bit to;
    logic [8:0] g;
    logic [7:0] e;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear();
    pulse(1'b1, 8'h41, 1'b1, 14'd12);
    exp_q.push_back(8'h41);
    for (int i = 0; i < 100 && got_q.size() < 1; i++) @(negedge clk);
    n_checks++; if (got_q.size() < 1) begin n_fail++; $display("FAIL rr_first_start: got %0d starts, required 1", got_q.size()); end
    pulse(1'b1, 8'h42, 1'b1, 14'd9876);
    push_count(9876);
    exp_q.push_back(8'h42);
    wait_idle(600, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL rr_idle: busy=%b after 600 cycles, required 0", busy); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = pop_got();
      n_checks++; if (g !== {1'b1, e}) begin n_fail++; $display("FAIL rr_byte: got %h, required %h", g, {1'b1, e}); end
    end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL rr_extra: got %0d extra starts, required 0", got_q.size()); end
  endtask

  task automatic test_latest_wins();
    bit to;
    logic [8:0] g;
    logic [7:0] e;
    clear();
    pulse(1'b0, 8'h00, 1'b1, 14'd5);
    push_count(5);
    exp_q.push_back(8'h35);
    for (int i = 0; i < 100 && got_q.size() < 1; i++) @(negedge clk);
    pulse(1'b1, 8'h31, 1'b0, 14'd0);
    repeat (3) @(negedge clk);
    pulse(1'b1, 8'h35, 1'b0, 14'd0);
    wait_idle(600, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL latest_idle: busy=%b after 600 cycles, required 0", busy); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = pop_got();
      n_checks++; if (g !== {1'b1, e}) begin n_fail++; $display("FAIL latest_byte: got %h, required %h", g, {1'b1, e}); end
    end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL latest_extra: got %0d extra starts, required 0", got_q.size()); end
  endtask

  task automatic test_hold_busy();
    bit to;
    logic [8:0] g;
    clear();
    hold_busy = 1'b1;
    pulse(1'b1, 8'h55, 1'b0, 14'd0);
    repeat (10) @(negedge clk);
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL hold_no_start: got %0d starts, required 0", got_q.size()); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy: got %b, required 1", busy); end
    hold_busy = 1'b0;
    wait_idle(200, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL hold_idle: busy=%b after 200 cycles, required 0", busy); end
    g = pop_got();
    n_checks++; if (g !== 9'h155) begin n_fail++; $display("FAIL hold_byte: got %h, required 155", g); end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL hold_extra: got %0d extra starts, required 0", got_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit to;
    logic [8:0] g;
    logic [7:0] e;
    clear();
    pulse(1'b1, 8'h61, 1'b0, 14'd0);
    pulse(1'b1, 8'h62, 1'b0, 14'd0);
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h62);
    wait_idle(300, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL b2b_idle: busy=%b after 300 cycles, required 0", busy); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = pop_got();
      n_checks++; if (g !== {1'b1, e}) begin n_fail++; $display("FAIL b2b_byte: got %h, required %h", g, {1'b1, e}); end
    end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL b2b_extra: got %0d extra starts, required 0", got_q.size()); end
  endtask

  task automatic test_reset_abort();
    bit to;
    logic [8:0] g;
    int lat;
    clear();
    pulse(1'b0, 8'h00, 1'b1, 14'd427);
    for (int i = 0; i < 200 && got_q.size() < 2; i++) @(negedge clk);
    n_checks++; if (got_q.size() != 2) begin n_fail++; $display("FAIL abort_two_starts: got %0d starts, required 2", got_q.size()); end
    @(negedge clk);
    reset = 1'b1;
    req_char = 1'b1;
    char_data = 8'h77;
    @(negedge clk);
    reset = 1'b0;
    req_char = 1'b0;
    repeat (40) @(negedge clk);
    g = pop_got();
    n_checks++; if (g !== 9'h130) begin n_fail++; $display("FAIL abort_byte0: got %h, required 130", g); end
    g = pop_got();
    n_checks++; if (g !== 9'h134) begin n_fail++; $display("FAIL abort_byte1: got %h, required 134", g); end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL abort_no_start: got %0d starts, required 0", got_q.size()); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b, required 0", busy); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL abort_tx_data: got %h, required 00", tx_data); end
    clear();
    pulse(1'b1, 8'h36, 1'b0, 14'd0);
    wait_idle(200, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL abort_fresh_idle: busy=%b after 200 cycles, required 0", busy); end
    lat = start_cyc_q.size() != 0 ? start_cyc_q[0] - req_edge : -1;
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL abort_fresh_latency: got %0d, required 2", lat); end
    g = pop_got();
    n_checks++; if (g !== 9'h136) begin n_fail++; $display("FAIL abort_fresh_byte: got %h, required 136", g); end
    n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL abort_fresh_extra: got %0d extra starts, required 0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_char();
    test_count(427, "cnt427");
    test_count(16383, "cnt_sat");
    test_count(0, "cnt0");
    test_round_robin();
    test_latest_wins();
    test_hold_busy();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at 1000000, required finish");
    $fatal(1);
  end
endmodule
